cic_decim_ctrl: RTL and testbench

Sequencing controller for one cic_decim instance.
- Generates the CIC's enable, input-strobe and output-strobe from a sample-valid stream and a programmable decimation rate.
- Holds the CIC in reset while idle and on every rate change.
- Masks the CIC's warm-up outputs so downstream sees only settled samples.
- Sits between the ADC/mixer stream and the decimator, configured by the register bank.

---
 rtl/cic_ctrl_pkg.sv | 21 ++
 rtl/cic_decim_phase_cnt.sv | 41 ++++
 rtl/cic_decim_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cic_decim_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_ctrl_pkg.sv
// Shared state encoding and width helper for the CIC decimator controller.
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        WARMUP = 2'd2,
        RUN    = 2'd3
    } ctrl_state_t;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cic_decim_phase_cnt.sv
// Modulo-rate phase counter: counts accepted input samples 0..rate-1 and
// flags the last sample of each decimation period.
module cic_decim_phase_cnt
    import cic_ctrl_pkg::*;
#(
    parameter int MAXRATE    = 64,
    parameter int RATE_WIDTH = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clr_i,
    input  logic                  sync_i,
    input  logic                  act_i,
    input  logic [RATE_WIDTH-1:0] rate_i,
    output logic                  act_out_o
);

    localparam int CNT_W = clog2(MAXRATE);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (RATE_WIDTH'(r_cnt) >= (rate_i - RATE_WIDTH'(1)));

    // A sync sample is index 0 of the new period, so it never terminates one.
    assign act_out_o = act_i && !sync_i && w_last;

    // Phase count: clear wins, then sync realignment, then normal advance.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (sync_i) begin
            r_cnt <= act_i ? CNT_W'(1) : '0;
        end else if (act_i) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for one cic_decim instance.
// state  | meaning
// IDLE   | disabled, CIC held in reset
// CLEAR  | CIC held in reset for CLEAR_CYCLES after start or rate change
// WARMUP | CIC running, outputs discarded until DISCARD have been seen
// RUN    | CIC running, outputs forwarded
module cic_decim_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int MAXRATE      = 64,
    parameter int RATE_WIDTH   = 7,
    parameter int DEFAULT_RATE = 64,
    parameter int CLEAR_CYCLES = 2,
    parameter int DISCARD      = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  data_valid_i,
    input  logic [RATE_WIDTH-1:0] rate_i,
    input  logic                  rate_wr_i,
    input  logic                  sync_i,
    input  logic                  cic_val_i,
    output logic                  cic_rst_o,
    output logic                  cic_en_o,
    output logic                  cic_act_o,
    output logic                  cic_act_out_o,
    output logic                  val_o,
    output logic [RATE_WIDTH-1:0] rate_o,
    output logic                  rate_err_o,
    output logic                  busy_o
);

    localparam int CLR_W  = clog2(CLEAR_CYCLES + 1);
    localparam int DISC_W = clog2(DISCARD + 1);

    ctrl_state_t           r_state;
    ctrl_state_t           w_state_nxt;
    logic [CLR_W-1:0]      r_clr_cnt;
    logic [CLR_W-1:0]      w_clr_cnt_nxt;
    logic [DISC_W-1:0]     r_disc_cnt;
    logic [DISC_W-1:0]     w_disc_cnt_nxt;
    logic [RATE_WIDTH-1:0] r_rate;
    logic                  r_rate_err;
    logic                  r_cic_rst;

    logic w_rate_legal;
    logic w_legal_wr;
    logic w_active;
    logic w_ph_clr;
    logic w_ph_sync;

    assign w_rate_legal = (rate_i >= RATE_WIDTH'(2)) && (rate_i <= RATE_WIDTH'(MAXRATE));
    assign w_legal_wr   = rate_wr_i && w_rate_legal;
    assign w_active     = (r_state == WARMUP) || (r_state == RUN);

    assign cic_en_o   = w_active;
    assign cic_act_o  = data_valid_i && w_active;
    assign val_o      = cic_val_i && (r_state == RUN);
    assign busy_o     = en_i && (r_state != RUN);
    assign rate_o     = r_rate;
    assign rate_err_o = r_rate_err;
    assign cic_rst_o  = r_cic_rst;

    // Phase counter is only meaningful while the CIC runs; restarts zero it.
    assign w_ph_clr  = !en_i || !w_active || w_legal_wr;
    assign w_ph_sync = en_i && sync_i && w_active && !w_legal_wr;

    cic_decim_phase_cnt #(
        .MAXRATE    (MAXRATE),
        .RATE_WIDTH (RATE_WIDTH)
    ) u_phase_cnt (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (w_ph_clr),
        .sync_i    (w_ph_sync),
        .act_i     (cic_act_o),
        .rate_i    (r_rate),
        .act_out_o (cic_act_out_o)
    );

    // Next state and counters; priority: disable, rate write, sync, normal flow.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_disc_cnt_nxt = r_disc_cnt;
        if (!en_i) begin
            w_state_nxt    = IDLE;
            w_clr_cnt_nxt  = '0;
            w_disc_cnt_nxt = '0;
        end else if (w_legal_wr && w_active) begin
            w_state_nxt    = CLEAR;
            w_clr_cnt_nxt  = '0;
            w_disc_cnt_nxt = '0;
        end else if (w_legal_wr && (r_state == CLEAR)) begin
            w_clr_cnt_nxt = '0;
        end else if (sync_i && w_active) begin
            w_state_nxt    = WARMUP;
            w_disc_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt   = CLEAR;
                    w_clr_cnt_nxt = '0;
                end
                CLEAR: begin
                    if (r_clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
                        w_state_nxt   = WARMUP;
                        w_clr_cnt_nxt = '0;
                    end else begin
                        w_clr_cnt_nxt = r_clr_cnt + CLR_W'(1);
                    end
                end
                WARMUP: begin
                    if (cic_val_i) begin
                        if (r_disc_cnt == DISC_W'(DISCARD - 1)) begin
                            w_state_nxt    = RUN;
                            w_disc_cnt_nxt = '0;
                        end else begin
                            w_disc_cnt_nxt = r_disc_cnt + DISC_W'(1);
                        end
                    end
                end
                RUN: begin
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counters and the registered CIC reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_clr_cnt  <= '0;
            r_disc_cnt <= '0;
            r_cic_rst  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_disc_cnt <= w_disc_cnt_nxt;
            r_cic_rst  <= (w_state_nxt == IDLE) || (w_state_nxt == CLEAR);
        end
    end

    // Rate register; a legal write is latched even while disabled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rate     <= RATE_WIDTH'(DEFAULT_RATE);
            r_rate_err <= 1'b0;
        end else begin
            r_rate_err <= rate_wr_i && !w_rate_legal;
            if (w_legal_wr) r_rate <= rate_i;
        end
    end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl: scoreboard of expected
// decimation-output sample indices, plus per-cycle output checks.
module tb_cic_decim_ctrl;

    logic       clk_i;
    logic       rst_n_i;
    logic       en_i;
    logic       data_valid_i;
    logic [6:0] rate_i;
    logic       rate_wr_i;
    logic       sync_i;
    logic       cic_val_i;
    logic       cic_rst_o;
    logic       cic_en_o;
    logic       cic_act_o;
    logic       cic_act_out_o;
    logic       val_o;
    logic [6:0] rate_o;
    logic       rate_err_o;
    logic       busy_o;

    int n_chk = 0;
    int n_err = 0;

    int q_act[$];
    int smp;
    int vp;
    int exp_rate;
    logic exp_en;
    logic exp_run;
    logic run_pending;

    cic_decim_ctrl dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .en_i          (en_i),
        .data_valid_i  (data_valid_i),
        .rate_i        (rate_i),
        .rate_wr_i     (rate_wr_i),
        .sync_i        (sync_i),
        .cic_val_i     (cic_val_i),
        .cic_rst_o     (cic_rst_o),
        .cic_en_o      (cic_en_o),
        .cic_act_o     (cic_act_o),
        .cic_act_out_o (cic_act_out_o),
        .val_o         (val_o),
        .rate_o        (rate_o),
        .rate_err_o    (rate_err_o),
        .busy_o        (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected decimation outputs: last sample of each period, indices from..to-1.
    task automatic push_exp(input int from, input int to, input int r);
        for (int k = from; k < to; k++)
            if (k % r == r - 1) q_act.push_back(k);
    endtask

    // One clock: drive at negedge+1, check combinational outputs, pass the
    // rising edge, check registered outputs at the following negedge+1.
    task automatic tick(input logic v, input logic cv, input logic sy,
                        input logic wr, input int r, input logic en);
        logic err_exp;
        data_valid_i = v;
        cic_val_i    = cv;
        sync_i       = sy;
        rate_wr_i    = wr;
        rate_i       = 7'(r);
        en_i         = en;
        err_exp      = wr && !(r >= 2 && r <= 64);
        if (wr && r >= 2 && r <= 64) exp_rate = r;
        #2;
        chk("cic_act", cic_act_o, v & exp_en);
        if (cv) begin
            chk("val_o", val_o, exp_run);
            if (exp_en && !exp_run) begin
                vp++;
                if (vp == 11) run_pending = 1'b1;
            end
        end
        if (cic_act_out_o) begin
            if (q_act.size() == 0) chk("act_out_extra", 1, 0);
            else chk("act_out_idx", smp, q_act.pop_front());
        end
        if (v && exp_en) smp++;
        @(negedge clk_i);
        #1;
        if (run_pending) begin
            exp_run     = 1'b1;
            run_pending = 1'b0;
        end
        chk("busy", busy_o, en && !exp_run);
        chk("rate_o", rate_o, exp_rate);
        chk("rate_err", rate_err_o, err_exp);
    endtask

    task automatic stream(input int n, input int per, input logic tog);
        logic v;
        logic cv;
        for (int i = 0; i < n; i++) begin
            v  = tog ? (i % 2 == 0) : 1'b1;
            cv = (per > 0) && (i % per == per - 1);
            tick(v, cv, 1'b0, 1'b0, 0, 1'b1);
        end
    endtask

    // Caller has just entered CLEAR; walk its two cycles into WARMUP.
    task automatic clear2(input logic v);
        exp_en  = 1'b0;
        exp_run = 1'b0;
        smp     = 0;
        vp      = 0;
        tick(v, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("clear_rst1", cic_rst_o, 1);
        chk("clear_en1", cic_en_o, 0);
        tick(v, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("clear_rst2", cic_rst_o, 0);
        chk("clear_en2", cic_en_o, 1);
        exp_en = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rate"}, rate_o, 64);
        chk({tag, "_cic_rst"}, cic_rst_o, 1);
        chk({tag, "_cic_en"}, cic_en_o, 0);
        chk({tag, "_act"}, cic_act_o, 0);
        chk({tag, "_act_out"}, cic_act_out_o, 0);
        chk({tag, "_val"}, val_o, 0);
        chk({tag, "_rate_err"}, rate_err_o, 0);
    endtask

    initial begin
        rst_n_i = 1'b0; en_i = 1'b0; data_valid_i = 1'b0; rate_i = '0;
        rate_wr_i = 1'b0; sync_i = 1'b0; cic_val_i = 1'b0;
        exp_rate = 64; exp_en = 1'b0; exp_run = 1'b0; run_pending = 1'b0;
        smp = 0; vp = 0;
        repeat (2) @(negedge clk_i);
        #1;
        check_reset_vals("rst");
        chk("rst_busy", busy_o, 0);
        rst_n_i = 1'b1;

        // Start-up at the default rate 64 with continuous valid input.
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("start_rst", cic_rst_o, 1);
        clear2(1'b1);
        push_exp(0, 200, 64);
        stream(200, 4, 1'b0);
        chk("s1_drain", q_act.size(), 0);

        // Rate change to 4 from RUN.
        exp_run = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1);
        chk("wr4_rst", cic_rst_o, 1);
        clear2(1'b1);
        push_exp(0, 120, 4);
        stream(120, 4, 1'b0);

        // Illegal rates: error pulse only, stream continues.
        push_exp(smp, smp + 24, 4);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 65, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("bad_wr_rst", cic_rst_o, 0);
        stream(20, 4, 1'b0);
        chk("s3_drain", q_act.size(), 0);

        // Rate 8 with half-rate valid, then sync at phase 5.
        exp_run = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b1);
        chk("wr8_rst", cic_rst_o, 1);
        clear2(1'b0);
        push_exp(0, 53, 8);
        stream(106, 4, 1'b1);
        chk("pre_sync_drain", q_act.size(), 0);
        exp_run = 1'b0;
        vp      = 0;
        smp     = 0;
        push_exp(0, 21, 8);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        chk("sync_en", cic_en_o, 1);
        chk("sync_rst", cic_rst_o, 0);
        stream(40, 4, 1'b1);
        push_exp(21, 31, 8);
        stream(20, 2, 1'b1);
        chk("s4_drain", q_act.size(), 0);

        // Rate write beats sync; then disable beats rate write.
        exp_run = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b1);
        chk("wr_sync_rst", cic_rst_o, 1);
        clear2(1'b1);
        push_exp(0, 40, 16);
        stream(40, 0, 1'b0);
        chk("s5_drain", q_act.size(), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        exp_en = 1'b0;
        chk("dis_rst", cic_rst_o, 1);
        chk("dis_en", cic_en_o, 0);

        // Run again, then async reset mid-RUN and restart.
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("re_rst", cic_rst_o, 1);
        clear2(1'b1);
        push_exp(0, 60, 16);
        stream(60, 4, 1'b0);
        chk("s6_drain", q_act.size(), 0);
        data_valid_i = 1'b1;
        cic_val_i    = 1'b1;
        en_i         = 1'b1;
        rst_n_i      = 1'b0;
        #1;
        check_reset_vals("arst");
        chk("arst_busy", busy_o, 1);
        @(negedge clk_i);
        #1;
        check_reset_vals("arst_hold");
        rst_n_i   = 1'b1;
        cic_val_i = 1'b0;
        exp_rate  = 64;
        exp_en    = 1'b0;
        exp_run   = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("restart_rst", cic_rst_o, 1);
        clear2(1'b1);
        push_exp(0, 140, 64);
        stream(140, 4, 1'b0);
        chk("final_drain", q_act.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
